// File: rtl/cbc_pkg.sv
// cbc_pkg: shared state encoding, mode constants and rotate/key-expansion helpers
package cbc_pkg;
    localparam int MAXW = 256;
    typedef logic [MAXW-1:0] wide_t;
    typedef enum logic [1:0] {IDLE, ROUND, OUT} state_t;
    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    function automatic wide_t rotl(input wide_t v, input int n, input int w);
        wide_t m;
        wide_t vm;
        int s;
        m = {MAXW{1'b1}} >> (MAXW - w);
        s = n % w;
        vm = v & m;
        return ((vm << s) | (vm >> (w - s))) & m;
    endfunction

    function automatic wide_t rotr(input wide_t v, input int n, input int w);
        return rotl(v, w - (n % w), w);
    endfunction

    function automatic wide_t key_expand(input wide_t k, input int bw, input int sw);
        wide_t r;
        r = '0;
        for (int i = 0; i < MAXW; i++)
            if (i < sw) r[i] = k[i % bw];
        return r;
    endfunction
endpackage

// File: rtl/cbc_engine_if.sv
// cbc_engine_if: key/iv/mode sideband plus input and output valid/ready streams
interface cbc_engine_if #(
    parameter int BLOCK_SIZE = 8,
    parameter int SYNC_SIZE  = 32
);
    logic [BLOCK_SIZE-1:0] key;
    logic [SYNC_SIZE-1:0]  iv;
    logic                  mode;
    logic                  s_valid;
    logic                  s_ready;
    logic [SYNC_SIZE-1:0]  s_data;
    logic                  s_first;
    logic                  m_valid;
    logic                  m_ready;
    logic [SYNC_SIZE-1:0]  m_data;
    logic                  busy;

    modport master (
        output key, iv, mode, s_valid, s_data, s_first, m_ready,
        input  s_ready, m_valid, m_data, busy
    );
    modport slave (
        input  key, iv, mode, s_valid, s_data, s_first, m_ready,
        output s_ready, m_valid, m_data, busy
    );
endinterface

// File: rtl/cbc_round.sv
// cbc_round: one keyed xor/rotate round, forward for encrypt and inverse for decrypt
module cbc_round
    import cbc_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] rk,
    input  logic         dir,
    output logic [W-1:0] y
);
    // encrypt mixes the key then rotates left; decrypt undoes that exactly
    always_comb
        y = dir == MODE_DEC ? W'(rotr(MAXW'(x), 1, W)) ^ rk
                            : W'(rotl(MAXW'(x ^ rk), 1, W));
endmodule

// File: rtl/cbc_engine.sv
// cbc_engine: iterative CBC encrypt/decrypt engine, one block in flight, one round per cycle
module cbc_engine
    import cbc_pkg::*;
#(
    parameter int BLOCK_SIZE = 8,
    parameter int SYNC_SIZE  = 32,
    parameter int ROUNDS     = 4
) (
    input logic         clk,
    input logic         rst,
    cbc_engine_if.slave bus
);
    localparam int CW = $clog2(ROUNDS + 1);
    localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         rid;
    logic [SYNC_SIZE-1:0]  x;
    logic [SYNC_SIZE-1:0]  cv;
    logic [SYNC_SIZE-1:0]  ct_hold;
    logic [SYNC_SIZE-1:0]  chain;
    logic [SYNC_SIZE-1:0]  cv_in;
    logic [SYNC_SIZE-1:0]  kexp;
    logic [SYNC_SIZE-1:0]  rk;
    logic [SYNC_SIZE-1:0]  nx;
    logic                  mode_q;
    logic [BLOCK_SIZE-1:0] key_q;

    assign bus.s_ready = state == IDLE;
    assign bus.busy    = state != IDLE;
    assign cv_in       = bus.s_first ? bus.iv : chain;
    assign kexp        = SYNC_SIZE'(key_expand(MAXW'(key_q), BLOCK_SIZE, SYNC_SIZE));
    // decrypt walks the round keys in reverse order
    assign rid         = mode_q == MODE_DEC ? LAST - cnt : cnt;
    assign rk          = SYNC_SIZE'(rotl(MAXW'(kexp), int'(rid), SYNC_SIZE));

    cbc_round #(.W(SYNC_SIZE)) u_round (
        .x  (x),
        .rk (rk),
        .dir(mode_q),
        .y  (nx)
    );

    // accept a block, iterate the rounds, then hold the result until downstream takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            x           <= '0;
            cv          <= '0;
            ct_hold     <= '0;
            chain       <= '0;
            mode_q      <= MODE_ENC;
            key_q       <= '0;
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.s_valid) begin
                    cv      <= cv_in;
                    mode_q  <= bus.mode;
                    key_q   <= bus.key;
                    x       <= bus.mode == MODE_DEC ? bus.s_data : bus.s_data ^ cv_in;
                    ct_hold <= bus.s_data;
                    cnt     <= '0;
                    state   <= ROUND;
                end
                ROUND: begin
                    x   <= nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state       <= OUT;
                        bus.m_valid <= 1'b1;
                        bus.m_data  <= mode_q == MODE_DEC ? nx ^ cv : nx;
                    end
                end
                OUT: if (bus.m_ready) begin
                    chain       <= mode_q == MODE_DEC ? ct_hold : x;
                    bus.m_valid <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cbc_engine.sv
// tb_cbc_engine: directed checks of a small 8-bit single-round engine and the default engine
module tb_cbc_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    cbc_engine_if #(.BLOCK_SIZE(4), .SYNC_SIZE(8)) a_if();
    cbc_engine_if b_if();

    cbc_engine #(.BLOCK_SIZE(4), .SYNC_SIZE(8), .ROUNDS(1)) dut_a (
        .clk(clk), .rst(rst), .bus(a_if)
    );
    cbc_engine dut_b (
        .clk(clk), .rst(rst), .bus(b_if)
    );

    function automatic logic [31:0] m_rotl(input logic [31:0] v, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) r[(i + n) % 32] = v[i];
        return r;
    endfunction

    function automatic logic [31:0] m_rk(input logic [7:0] k, input int r);
        logic [31:0] e;
        for (int i = 0; i < 32; i++) e[i] = k[i % 8];
        return m_rotl(e, r % 32);
    endfunction

    function automatic logic [31:0] m_enc(input logic [31:0] p, input logic [31:0] cv, input logic [7:0] k);
        logic [31:0] x;
        x = p ^ cv;
        for (int r = 0; r < 4; r++) x = m_rotl(x ^ m_rk(k, r), 1);
        return x;
    endfunction

    task automatic a_send(input logic [7:0] d, input logic first, input logic md, output bit ok);
        int n = 0;
        a_if.s_data = d; a_if.s_first = first; a_if.mode = md; a_if.s_valid = 1'b1;
        ok = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (a_if.s_ready) begin @(posedge clk); #1; ok = 1; end
            n++;
        end
        a_if.s_valid = 1'b0;
    endtask

    task automatic a_recv(input int gap, output logic [7:0] d, output bit ok);
        int n = 0;
        ok = 0;
        while (!ok && n < 50) begin @(negedge clk); ok = a_if.m_valid; n++; end
        repeat (gap) @(negedge clk);
        d = a_if.m_data;
        a_if.m_ready = 1'b1; @(posedge clk); #1; a_if.m_ready = 1'b0;
    endtask

    task automatic b_send(input logic [31:0] d, input logic first, input logic md, input int gap, output bit ok);
        int n = 0;
        repeat (gap) begin @(posedge clk); #1; end
        b_if.s_data = d; b_if.s_first = first; b_if.mode = md; b_if.s_valid = 1'b1;
        ok = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (b_if.s_ready) begin @(posedge clk); #1; ok = 1; end
            n++;
        end
        b_if.s_valid = 1'b0;
    endtask

    task automatic b_recv(input int gap, output logic [31:0] d, output bit ok);
        int n = 0;
        ok = 0;
        while (!ok && n < 50) begin @(negedge clk); ok = b_if.m_valid; n++; end
        repeat (gap) @(negedge clk);
        d = b_if.m_data;
        b_if.m_ready = 1'b1; @(posedge clk); #1; b_if.m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (a_if.s_ready !== 1'b1) begin n_bad++; $display("FAIL rst_a_s_ready got %b want 1", a_if.s_ready); end
        n_cmp++; if (a_if.m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_a_m_valid got %b want 0", a_if.m_valid); end
        n_cmp++; if (a_if.m_data !== 8'h00) begin n_bad++; $display("FAIL rst_a_m_data got %h want 00", a_if.m_data); end
        n_cmp++; if (a_if.busy !== 1'b0) begin n_bad++; $display("FAIL rst_a_busy got %b want 0", a_if.busy); end
        n_cmp++; if (b_if.m_valid !== 1'b0 || b_if.busy !== 1'b0 || b_if.s_ready !== 1'b1) begin
            n_bad++; $display("FAIL rst_b_flags got v=%b b=%b r=%b want 0 0 1", b_if.m_valid, b_if.busy, b_if.s_ready);
        end
        n_cmp++; if (b_if.m_data !== 32'h0) begin n_bad++; $display("FAIL rst_b_m_data got %h want 0", b_if.m_data); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_encrypt_chain();
        bit ok;
        logic [7:0] d;
        a_if.key = 4'hA; a_if.iv = 8'h00;
        a_send(8'h0F, 1'b1, 1'b0, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL enc0_accept got timeout want accept"); end
        @(negedge clk);
        n_cmp++; if (a_if.busy !== 1'b1 || a_if.m_valid !== 1'b0) begin
            n_bad++; $display("FAIL enc0_round got busy=%b m_valid=%b want 1 0", a_if.busy, a_if.m_valid);
        end
        @(posedge clk); #1;
        n_cmp++; if (a_if.m_valid !== 1'b1 || a_if.m_data !== 8'h4B) begin
            n_bad++; $display("FAIL enc0_latency got v=%b d=%h want 1 4b", a_if.m_valid, a_if.m_data);
        end
        a_recv(0, d, ok);
        n_cmp++; if (d !== 8'h4B) begin n_bad++; $display("FAIL enc0_data got %h want 4b", d); end
        a_if.iv = 8'h77;
        a_send(8'h0F, 1'b0, 1'b0, ok);
        a_recv(1, d, ok);
        n_cmp++; if (!ok || d !== 8'hDD) begin n_bad++; $display("FAIL enc1_chain got %h ok=%b want dd", d, ok); end
    endtask

    task automatic test_decrypt();
        bit ok;
        logic [7:0] d;
        a_if.key = 4'hA; a_if.iv = 8'h00;
        a_send(8'h4B, 1'b1, 1'b1, ok);
        a_recv(0, d, ok);
        n_cmp++; if (!ok || d !== 8'h0F) begin n_bad++; $display("FAIL dec0_data got %h ok=%b want 0f", d, ok); end
        a_if.iv = 8'h5A;
        a_send(8'hDD, 1'b0, 1'b1, ok);
        a_recv(2, d, ok);
        n_cmp++; if (!ok || d !== 8'h0F) begin n_bad++; $display("FAIL dec1_chain got %h ok=%b want 0f", d, ok); end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [7:0] d;
        int n = 0;
        a_if.key = 4'hA; a_if.iv = 8'h00;
        a_send(8'h0F, 1'b1, 1'b0, ok);
        while (!a_if.m_valid && n < 20) begin @(negedge clk); n++; end
        a_if.s_valid = 1'b1; a_if.s_data = 8'hC3; a_if.s_first = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp++; if (a_if.m_valid !== 1'b1 || a_if.m_data !== 8'h4B || a_if.s_ready !== 1'b0) begin
                n_bad++; $display("FAIL stall_hold cyc %0d got v=%b d=%h r=%b want 1 4b 0", c, a_if.m_valid, a_if.m_data, a_if.s_ready);
            end
        end
        a_if.s_valid = 1'b0;
        a_recv(0, d, ok);
        n_cmp++; if (d !== 8'h4B) begin n_bad++; $display("FAIL stall_data got %h want 4b", d); end
        a_send(8'h0F, 1'b0, 1'b0, ok);
        a_recv(0, d, ok);
        n_cmp++; if (!ok || d !== 8'hDD) begin n_bad++; $display("FAIL stall_chain got %h ok=%b want dd", d, ok); end
    endtask

    task automatic test_latency_default();
        bit ok;
        logic [31:0] d;
        b_if.key = 8'h3C; b_if.iv = 32'hDEAD_BEEF;
        b_send(32'h0123_4567, 1'b1, 1'b0, 0, ok);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (b_if.m_valid !== 1'b0) begin n_bad++; $display("FAIL lat_early got %b want 0", b_if.m_valid); end
        @(posedge clk); #1;
        n_cmp++; if (b_if.m_valid !== 1'b1) begin n_bad++; $display("FAIL lat_on_time got %b want 1", b_if.m_valid); end
        b_recv(0, d, ok);
        n_cmp++; if (d !== m_enc(32'h0123_4567, 32'hDEAD_BEEF, 8'h3C)) begin
            n_bad++; $display("FAIL lat_data got %h want %h", d, m_enc(32'h0123_4567, 32'hDEAD_BEEF, 8'h3C));
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit rose = 0;
        logic [31:0] d;
        b_if.key = 8'h5C; b_if.iv = 32'h1234_5678;
        b_send(32'hAAAA_0001, 1'b1, 1'b0, 0, ok);
        b_recv(0, d, ok);
        n_cmp++; if (d !== m_enc(32'hAAAA_0001, 32'h1234_5678, 8'h5C)) begin
            n_bad++; $display("FAIL rmid_pre got %h want %h", d, m_enc(32'hAAAA_0001, 32'h1234_5678, 8'h5C));
        end
        b_send(32'hBBBB_0002, 1'b0, 1'b0, 0, ok);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (b_if.busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got %b want 0", b_if.busy); end
        for (int c = 0; c < 10; c++) begin @(negedge clk); if (b_if.m_valid) rose = 1; end
        n_cmp++; if (rose) begin n_bad++; $display("FAIL rmid_no_output got m_valid rise want none"); end
        b_if.iv = 32'hFFFF_FFFF;
        b_send(32'hCCCC_0003, 1'b0, 1'b0, 0, ok);
        b_recv(0, d, ok);
        n_cmp++; if (!ok || d !== m_enc(32'hCCCC_0003, 32'h0, 8'h5C)) begin
            n_bad++; $display("FAIL rmid_chain0 got %h want %h", d, m_enc(32'hCCCC_0003, 32'h0, 8'h5C));
        end
    endtask

    task automatic test_roundtrip();
        logic [31:0] pt [200];
        logic [31:0] ct [200];
        bit          fst [200];
        int          msg [200];
        logic [31:0] ivs [3];
        logic [31:0] prev = '0;
        logic [31:0] exp;
        logic [31:0] d;
        bit ok;
        logic [7:0] k;
        k = 8'($urandom);
        b_if.key = k;
        for (int m = 0; m < 3; m++) ivs[m] = $urandom;
        for (int i = 0; i < 200; i++) begin
            pt[i] = $urandom;
            msg[i] = i < 70 ? 0 : i < 140 ? 1 : 2;
            fst[i] = i == 0 || i == 70 || i == 140;
        end
        for (int i = 0; i < 200; i++) begin
            b_if.iv = fst[i] ? ivs[msg[i]] : $urandom;
            exp = m_enc(pt[i], fst[i] ? ivs[msg[i]] : prev, k);
            b_send(pt[i], fst[i], 1'b0, $urandom_range(0, 3), ok);
            b_recv($urandom_range(0, 3), d, ok);
            ct[i] = d;
            prev = exp;
            n_cmp++; if (!ok || d !== exp) begin n_bad++; $display("FAIL rt_enc[%0d] got %h want %h", i, d, exp); end
        end
        for (int i = 0; i < 200; i++) begin
            b_if.iv = fst[i] ? ivs[msg[i]] : $urandom;
            b_send(ct[i], fst[i], 1'b1, $urandom_range(0, 3), ok);
            b_recv($urandom_range(0, 3), d, ok);
            n_cmp++; if (!ok || d !== pt[i]) begin n_bad++; $display("FAIL rt_dec[%0d] got %h want %h", i, d, pt[i]); end
        end
    endtask

    initial begin
        a_if.key = '0; a_if.iv = '0; a_if.mode = 1'b0; a_if.s_valid = 1'b0;
        a_if.s_data = '0; a_if.s_first = 1'b0; a_if.m_ready = 1'b0;
        b_if.key = '0; b_if.iv = '0; b_if.mode = 1'b0; b_if.s_valid = 1'b0;
        b_if.s_data = '0; b_if.s_first = 1'b0; b_if.m_ready = 1'b0;
        test_reset();
        test_encrypt_chain();
        test_decrypt();
        test_backpressure();
        test_latency_default();
        test_reset_mid();
        test_roundtrip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
